// File: rtl/gate_chk_pkg.sv
// Shared types and reference truth tables for the gate truth-table checker.
// Truth-table bit i is the expected gate output for input vector i.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } gate_chk_state_e;

    localparam logic [3:0] NOR2_TT  = 4'b0001;
    localparam logic [3:0] NAND2_TT = 4'b0111;
    localparam logic [3:0] AND2_TT  = 4'b1000;
    localparam logic [3:0] OR2_TT   = 4'b1110;
    localparam logic [3:0] XOR2_TT  = 4'b0110;

endpackage

// File: rtl/gate_chk_settle_cnt.sv
// Loadable down-counter that measures the settle time of each applied vector.
// It reloads to SETTLE_CYCLES-1, so the zero flag rises after SETTLE_CYCLES clocks.
module gate_chk_settle_cnt #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(SETTLE_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_tt_checker.sv
// Walks all 2^N_IN input vectors of a gate under test and counts outputs that differ from TRUTH.
// Optional first-failure capture (fail_valid/fail_vec) is enabled by defining GATE_CHK_FIRST_FAIL_EN.
module gate_tt_checker
    import gate_chk_pkg::*;
#(
    parameter int                     N_IN          = 2,
    parameter logic [(2**N_IN)-1:0]   TRUTH         = NOR2_TT,
    parameter int                     SETTLE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            gate_out,
    output logic [N_IN-1:0] gate_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
`ifdef GATE_CHK_FIRST_FAIL_EN
    output logic            fail_valid,
    output logic [N_IN-1:0] fail_vec,
`endif
    output logic [1:0]      state_dbg_o
);

    localparam logic [N_IN-1:0] LAST_VEC = '1;

    gate_chk_state_e state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [N_IN:0]   err_q, err_d, err_inc;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            cnt_load, cnt_dec, cnt_zero;
    logic            mismatch;

    gate_chk_settle_cnt #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_cnt (
        .clk   (clk),
        .rst   (rst),
        .load_i(cnt_load),
        .dec_i (cnt_dec),
        .zero_o(cnt_zero)
    );

    assign mismatch = (state_q == CHECK) && (gate_out != TRUTH[vec_q]);
    assign err_inc  = err_q + {{N_IN{1'b0}}, mismatch};

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        err_d    = err_q;
        busy_d   = busy_q;
        pass_d   = pass_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d    = '0;
                    err_d    = '0;
                    pass_d   = 1'b0;
                    busy_d   = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_zero) begin
                    state_d = CHECK;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            CHECK: begin
                err_d = err_inc;
                // Outputs for the DONE cycle are registered here so done/busy/pass line up.
                if (vec_q == LAST_VEC) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (err_inc == '0);
                    state_d = DONE;
                end else begin
                    vec_d    = vec_q + 1'b1;
                    cnt_load = 1'b1;
                    state_d  = SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

`ifdef GATE_CHK_FIRST_FAIL_EN
    logic            fail_valid_q, fail_valid_d;
    logic [N_IN-1:0] fail_vec_q, fail_vec_d;

    always_comb begin
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        if ((state_q == IDLE) && start) begin
            fail_valid_d = 1'b0;
            fail_vec_d   = '0;
        end else if (mismatch && !fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
        end else begin
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
        end
    end

    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;
`endif

    assign gate_in     = vec_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_cnt     = err_q;
    assign state_dbg_o = state_q;

endmodule
